equiv_checker: RTL and testbench

EQUIV_CHECKER -- requirements
Module: equiv_checker

---
 rtl/equiv_pkg.sv | 19 +
 rtl/hold_timer.sv | 41 ++++
 rtl/equiv_checker.sv | 124 ++++++++++++
 tb/tb_equiv_checker.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/equiv_pkg.sv
// equiv_pkg
//   Shared types and sizes for the equivalence checker.
//   state_t   : run controller states (IDLE, DRIVE, DONE)
//   VEC_W     : width of the {a,b,c,d} stimulus vector
//   NUM_VEC   : number of vectors in an exhaustive run
//   ERR_W     : width of the mismatch counter (must hold 0..NUM_VEC)
package equiv_pkg;

    localparam int VEC_W   = 4;
    localparam int NUM_VEC = 16;
    localparam int ERR_W   = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/hold_timer.sv
// hold_timer
//   Counts 0..HOLD-1 while enabled, then wraps to 0. The terminal-count output
//   is high whenever the count sits at HOLD-1.
//   Ports:
//     clk   : clock, rising edge
//     rst_n : asynchronous active-low reset, count -> 0
//     clr   : synchronous clear to 0 (has priority over en)
//     en    : advance the count
//     tc    : count == HOLD-1
//   HOLD legal range is 1..255; HOLD=1 makes tc permanently high.
module hold_timer #(
    parameter int HOLD = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [7:0] LAST = 8'(HOLD - 1);

    logic [7:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 8'd0;
        end else if (clr) begin
            count <= 8'd0;
        end else if (en) begin
            if (count == LAST) begin
                count <= 8'd0;
            end else begin
                count <= count + 8'd1;
            end
        end
    end

    assign tc = (count == LAST);

endmodule

// File: rtl/equiv_checker.sv
// equiv_checker
//   Walks all 16 input vectors {a,b,c,d} in ascending order, holding each for
//   HOLD cycles, and compares the responses of two implementations (f_e, f_s)
//   on the last cycle of each hold window.
//   Ports:
//     clk, rst_n  : clock (rising edge) / asynchronous active-low reset
//     start       : one-cycle request; accepted in IDLE or DONE, ignored in DRIVE.
//                   There is no ready/acknowledge: acceptance is visible as busy
//                   rising in the following cycle.
//     vec         : stimulus {a,b,c,d}, a = bit 3
//     f_e, f_s    : responses under check
//     busy        : run in progress
//     done        : run complete, held until next start or reset
//     pass        : valid while done; no mismatch seen
//     err_cnt     : number of mismatching vectors (0..16, saturating)
//     first_fail  : first mismatching vector, valid with fail_valid
//     fail_valid  : at least one mismatch recorded
//     mismatch    : one-cycle pulse after each mismatching sample
//     state_dbg   : current controller state (equiv_pkg::state_t encoding)
module equiv_checker
    import equiv_pkg::*;
#(
    parameter int HOLD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [VEC_W-1:0] vec,
    input  logic             f_e,
    input  logic             f_s,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [VEC_W-1:0] first_fail,
    output logic             fail_valid,
    output logic             mismatch,
    output logic [1:0]       state_dbg
);

    localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = ERR_W'(NUM_VEC);

    state_t state;
    logic   tc;
    logic   accept;
    logic   sample;
    logic   diff;

    // A start is only honoured outside DRIVE; in DRIVE it is dropped entirely.
    assign accept = start && (state != DRIVE);
    // tc is also high outside DRIVE (always, when HOLD=1), so gate it.
    assign sample = (state == DRIVE) && tc;
    assign diff   = f_e ^ f_s;

    hold_timer #(
        .HOLD (HOLD)
    ) u_hold_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .en    (state == DRIVE),
        .tc    (tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            vec        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
            first_fail <= '0;
            fail_valid <= 1'b0;
            mismatch   <= 1'b0;
        end else begin
            mismatch <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        state      <= DRIVE;
                        vec        <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        err_cnt    <= '0;
                        first_fail <= '0;
                        fail_valid <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (sample) begin
                        if (diff) begin
                            mismatch <= 1'b1;
                            if (err_cnt != ERR_MAX) begin
                                err_cnt <= err_cnt + ERR_W'(1);
                            end
                            if (!fail_valid) begin
                                first_fail <= vec;
                                fail_valid <= 1'b1;
                            end
                        end
                        if (vec == LAST_VEC) begin
                            // Include this last sample in the verdict.
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_cnt == '0) && !diff;
                        end else begin
                            vec <= vec + VEC_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_equiv_checker.sv
// tb_equiv_checker
//   Two checker instances (HOLD=4 and HOLD=1) share one clock and reset.
//   Each instance's f_e is the reference expression (a&b)|(~c&d); f_s is f_e
//   flipped on the vectors selected by a 16-bit fault mask, so the expected
//   results of a run follow directly from the mask.
module tb_equiv_checker;

    logic        clk;
    logic        rst_n;
    logic        start_s  [2];
    logic [3:0]  vec_s    [2];
    logic        fe_s     [2];
    logic        fs_s     [2];
    logic        busy_s   [2];
    logic        done_s   [2];
    logic        pass_s   [2];
    logic [4:0]  err_s    [2];
    logic [3:0]  ff_s     [2];
    logic        fv_s     [2];
    logic        mm_s     [2];
    logic [1:0]  st_s     [2];
    logic [15:0] mask_s   [2];
    int          mm_cnt   [2];

    int n_cmp;
    int n_err;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    assign fe_s[0] = (vec_s[0][3] & vec_s[0][2]) | (~vec_s[0][1] & vec_s[0][0]);
    assign fs_s[0] = fe_s[0] ^ mask_s[0][vec_s[0]];
    assign fe_s[1] = (vec_s[1][3] & vec_s[1][2]) | (~vec_s[1][1] & vec_s[1][0]);
    assign fs_s[1] = fe_s[1] ^ mask_s[1][vec_s[1]];

    equiv_checker #(.HOLD(4)) u_dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start_s[0]),
        .vec        (vec_s[0]),
        .f_e        (fe_s[0]),
        .f_s        (fs_s[0]),
        .busy       (busy_s[0]),
        .done       (done_s[0]),
        .pass       (pass_s[0]),
        .err_cnt    (err_s[0]),
        .first_fail (ff_s[0]),
        .fail_valid (fv_s[0]),
        .mismatch   (mm_s[0]),
        .state_dbg  (st_s[0])
    );

    equiv_checker #(.HOLD(1)) u_dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start_s[1]),
        .vec        (vec_s[1]),
        .f_e        (fe_s[1]),
        .f_s        (fs_s[1]),
        .busy       (busy_s[1]),
        .done       (done_s[1]),
        .pass       (pass_s[1]),
        .err_cnt    (err_s[1]),
        .first_fail (ff_s[1]),
        .fail_valid (fv_s[1]),
        .mismatch   (mm_s[1]),
        .state_dbg  (st_s[1])
    );

    // Count mismatch pulses (one per high cycle) per instance.
    always @(negedge clk) begin
        if (mm_s[0] === 1'b1) mm_cnt[0] = mm_cnt[0] + 1;
        if (mm_s[1] === 1'b1) mm_cnt[1] = mm_cnt[1] + 1;
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int ref_err_cnt(input logic [15:0] m);
        int n = 0;
        for (int v = 0; v < 16; v++) if (m[v]) n++;
        return n;
    endfunction

    function automatic int ref_first_fail(input logic [15:0] m);
        for (int v = 0; v < 16; v++) if (m[v]) return v;
        return 0;
    endfunction

    task automatic check_all_zero(input int k, input string tag);
        check({tag, "_vec"},  {28'd0, vec_s[k]}, 0);
        check({tag, "_busy"}, {31'd0, busy_s[k]}, 0);
        check({tag, "_done"}, {31'd0, done_s[k]}, 0);
        check({tag, "_pass"}, {31'd0, pass_s[k]}, 0);
        check({tag, "_err"},  {27'd0, err_s[k]}, 0);
        check({tag, "_ff"},   {28'd0, ff_s[k]}, 0);
        check({tag, "_fv"},   {31'd0, fv_s[k]}, 0);
        check({tag, "_mm"},   {31'd0, mm_s[k]}, 0);
    endtask

    // ---------------- driver: one full run ----------------
    // restart_at >= 0 re-pulses start at that DRIVE cycle (must be ignored).
    task automatic run_check(input int k, input logic [15:0] mask, input int restart_at);
        int hold;
        int cyc;
        int bad_vec;
        hold = (k == 0) ? 4 : 1;
        @(negedge clk);
        mask_s[k]  = mask;
        mm_cnt[k]  = 0;
        start_s[k] = 1'b1;
        @(negedge clk);
        start_s[k] = 1'b0;
        check("start_busy", {31'd0, busy_s[k]}, 1);
        check("start_done", {31'd0, done_s[k]}, 0);
        cyc     = 0;
        bad_vec = 0;
        while (busy_s[k] === 1'b1 && cyc < 16 * hold + 20) begin
            if (vec_s[k] !== 4'(cyc / hold)) bad_vec++;
            start_s[k] = (cyc == restart_at);
            cyc++;
            @(negedge clk);
        end
        start_s[k] = 1'b0;
        check("drive_len",  cyc, 16 * hold);
        check("vec_seq",    bad_vec, 0);
        check("done",       {31'd0, done_s[k]}, 1);
        check("busy_end",   {31'd0, busy_s[k]}, 0);
        check("pass",       {31'd0, pass_s[k]}, (mask == 16'd0) ? 1 : 0);
        check("err_cnt",    {27'd0, err_s[k]}, ref_err_cnt(mask));
        check("fail_valid", {31'd0, fv_s[k]}, (mask != 16'd0) ? 1 : 0);
        check("first_fail", {28'd0, ff_s[k]}, ref_first_fail(mask));
        check("vec_end",    {28'd0, vec_s[k]}, 15);
        check("state_done", {30'd0, st_s[k]}, 2);
        @(negedge clk);
        check("mm_pulses",  mm_cnt[k], ref_err_cnt(mask));
        check("done_hold",  {31'd0, done_s[k]}, 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        n_cmp      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        start_s[0] = 1'b0;
        start_s[1] = 1'b0;
        mask_s[0]  = 16'd0;
        mask_s[1]  = 16'd0;
        mm_cnt[0]  = 0;
        mm_cnt[1]  = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state, and idle holds without start
        check_all_zero(0, "rst4");
        check_all_zero(1, "rst1");
        check("rst_state", {30'd0, st_s[0]}, 0);

        // Identical functions, HOLD=4
        run_check(0, 16'h0000, -1);
        // Single fault at vector 5
        run_check(0, 16'h0020, -1);
        // Every vector differs, HOLD=1: counter reaches 16 without wrapping
        run_check(1, 16'hFFFF, -1);
        // Start re-pulsed 10 cycles into a run is ignored
        run_check(0, 16'h0100, 10);
        // Faults at 3 and 12, then restart from DONE with identical functions
        run_check(0, 16'h1008, -1);
        run_check(0, 16'h0000, -1);
        // Restart from DONE on HOLD=1 after all-fail run
        run_check(1, 16'h0000, -1);

        // Reset mid-run while vec == 7 (faults at 1 and 2 already counted)
        @(negedge clk);
        mask_s[0]  = 16'h0006;
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        for (int t = 0; t < 200 && vec_s[0] !== 4'd7; t++) @(negedge clk);
        check("reach_vec7", {28'd0, vec_s[0]}, 7);
        check("pre_rst_err", {27'd0, err_s[0]}, 2);
        rst_n = 1'b0;
        #1;
        check_all_zero(0, "midrst");
        check("midrst_state", {30'd0, st_s[0]}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check_all_zero(0, "post_rst");

        // Randomized runs against the model
        for (int i = 0; i < 6; i++) begin
            logic [15:0] m;
            m = 16'($urandom);
            if ($urandom_range(0, 3) == 0) m = 16'd0;
            run_check(i % 2, m, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
